// File: rtl/and_seq_checker.sv
// Synthesizable monitor for $rose(start) |=> (##A_DELAY a) and (b ##STOP_DELAY stop).
// Tracks overlapping attempts in an alive shift register and reports pass/fail with saturating statistics.
module and_seq_checker #(
  parameter int A_DELAY    = 1,
  parameter int STOP_DELAY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             stop,
  output logic             pass_o,
  output logic             fail_o,
  output logic [2:0]       fail_why_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] attempt_cnt_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  localparam int MAX_D = (A_DELAY > STOP_DELAY) ? A_DELAY : STOP_DELAY;
  localparam int L     = 1 + MAX_D;
  localparam int A_STG = 1 + A_DELAY;
  localparam int S_STG = 1 + STOP_DELAY;
  localparam logic [CNT_W+7:0] SAT_MAX = {8'd0, {CNT_W{1'b1}}};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x,
                                               input logic [7:0] n);
    logic [CNT_W+7:0] s;
    s = {8'd0, x} + {{CNT_W{1'b0}}, n};
    if (s > SAT_MAX) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic         start_q;
  logic         rose_p0;
  logic [L:1]   alive_p1;
  logic [L:1]   miss_b;
  logic [L:1]   miss_a;
  logic [L:1]   miss_s;
  logic [L:1]   bad;
  logic [L:1]   ok;
  logic [L:1]   alive_nxt;
  logic [2:0]   why_c;
  logic [7:0]   nfail;

  // Stage 0: rise detection against the previous sample of start
  assign rose_p0 = start & ~start_q;

  // Stages 1..L: every alive attempt is judged by the checks owned by its stage
  always_comb begin
    miss_b    = '0;
    miss_a    = '0;
    miss_s    = '0;
    bad       = '0;
    ok        = '0;
    why_c     = '0;
    nfail     = '0;
    alive_nxt = '0;
    for (int k = 1; k <= L; k++) begin
      miss_b[k] = alive_p1[k] & (k == 1)     & ~b;
      miss_a[k] = alive_p1[k] & (k == A_STG) & ~a;
      miss_s[k] = alive_p1[k] & (k == S_STG) & ~stop;
      bad[k]    = miss_b[k] | miss_a[k] | miss_s[k];
      ok[k]     = alive_p1[k] & ~bad[k];
      why_c     = why_c | {miss_s[k], miss_a[k], miss_b[k]};
      nfail     = nfail + {7'd0, bad[k]};
    end
    // Survivors advance one stage; the last stage retires as a pass
    alive_nxt = {ok[L-1:1], rose_p0};
  end

  // Output registers: one-cycle result pulses and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q       <= 1'b0;
      alive_p1      <= '0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      fail_why_o    <= 3'b000;
      busy_o        <= 1'b0;
      attempt_cnt_o <= '0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
    end else begin
      start_q       <= start;
      alive_p1      <= alive_nxt;
      pass_o        <= ok[L];
      fail_o        <= |bad;
      fail_why_o    <= why_c;
      busy_o        <= |alive_nxt;
      attempt_cnt_o <= sat_add(attempt_cnt_o, {7'd0, rose_p0});
      pass_cnt_o    <= sat_add(pass_cnt_o, {7'd0, ok[L]});
      fail_cnt_o    <= sat_add(fail_cnt_o, nfail);
    end
  end

endmodule
